// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM byte sequencer: FSM encoding and write-cycle timing.
package eeprom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        WR_WAIT,
        NEXT,
        FINISH
    } state_t;

    localparam int unsigned HZ_PER_MHZ = 1_000_000;

    // Cycles the EEPROM needs to commit a byte, derived from clock rate and wait time.
    function automatic int unsigned calc_wr_wait_cyc(input int unsigned sys_clk_hz,
                                                     input int unsigned wait_us);
        return (sys_clk_hz / HZ_PER_MHZ) * wait_us;
    endfunction

endpackage

// File: rtl/eeprom_buf_ram.sv
// Byte buffer for the sequencer: one write port, one registered read port with read enable.
module eeprom_buf_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/eeprom_seq_ctrl.sv
// Splits a multi-byte EEPROM request into single-byte IIC driver operations,
// with per-byte retry on ACK failure and the EEPROM write-cycle wait between writes.
module eeprom_seq_ctrl
    import eeprom_pkg::*;
#(
    parameter int SYS_CLK       = 50_000_000,
    parameter int ADDR_BYTE_NUM = 1,
    parameter int BUF_DEPTH     = 16,
    parameter int WR_WAIT_US    = 5000,
    parameter int MAX_RETRY     = 3,
    localparam int AW           = $clog2(BUF_DEPTH),
    localparam int WAW          = ADDR_BYTE_NUM * 8
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           req_start,
    input  logic           req_rw,
    input  logic [WAW-1:0] req_addr,
    input  logic [AW:0]    req_len,
    output logic           req_ready,
    input  logic           buf_we,
    input  logic [AW-1:0]  buf_waddr,
    input  logic [7:0]     buf_wdata,
    output logic [7:0]     rd_data,
    output logic [AW-1:0]  rd_index,
    output logic           rd_valid,
    output logic           done,
    output logic           error,
    output logic           iic_start,
    input  logic           iic_ready,
    output logic           iic_rw_flag,
    output logic [WAW-1:0] iic_word_addr,
    output logic [7:0]     iic_wdata,
    input  logic [7:0]     iic_rdata,
    input  logic           iic_rdata_valid,
    input  logic           iic_ack_error
);

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);
    localparam logic [31:0]   WR_WAIT_CYC = calc_wr_wait_cyc(SYS_CLK, WR_WAIT_US);

    state_t         state;
    logic           rw_q;
    logic [WAW-1:0] addr_q;
    logic [AW:0]    len_q;
    logic [AW-1:0]  idx;
    logic [RW-1:0]  retry;
    logic           ack_err;
    logic [31:0]    wait_cnt;

    logic [AW:0]    idx_nx;
    logic           last;
    logic           rd_strobe;

    logic           ram_we;
    logic [AW-1:0]  ram_waddr;
    logic [7:0]     ram_wdata;
    logic           ram_re;
    logic [AW-1:0]  ram_raddr;
    logic [7:0]     ram_rdata;

    assign idx_nx    = {1'b0, idx} + (AW+1)'(1);
    assign last      = (idx_nx == len_q);
    assign rd_strobe = rw_q && iic_rdata_valid && (state == WAIT_BUSY || state == WAIT_DONE);

    // The read port only fires the cycle before ISSUE, so the byte sent is frozen
    // at that point even if ISSUE stalls on a busy driver.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = buf_waddr;
        ram_wdata = buf_wdata;
        ram_re    = 1'b0;
        ram_raddr = idx;
        case (state)
            IDLE: begin
                ram_we    = buf_we;
                ram_re    = 1'b1;
                ram_raddr = '0;
            end
            NEXT: begin
                ram_re = 1'b1;
                if (!ack_err && !last) ram_raddr = idx_nx[AW-1:0];
            end
            WAIT_BUSY, WAIT_DONE: begin
                if (rd_strobe) begin
                    ram_we    = 1'b1;
                    ram_waddr = idx;
                    ram_wdata = iic_rdata;
                end
            end
            default: ;
        endcase
    end

    eeprom_buf_ram #(
        .DEPTH (BUF_DEPTH),
        .AW    (AW)
    ) u_buf (
        .sys_clk (sys_clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .re      (ram_re),
        .raddr   (ram_raddr),
        .rdata   (ram_rdata)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            idx           <= '0;
            retry         <= '0;
            ack_err       <= 1'b0;
            wait_cnt      <= '0;
            req_ready     <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            iic_start     <= 1'b0;
            iic_rw_flag   <= 1'b0;
            iic_word_addr <= '0;
            iic_wdata     <= '0;
            rd_data       <= '0;
            rd_index      <= '0;
            rd_valid      <= 1'b0;
        end else begin
            iic_start <= 1'b0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_start) begin
                        rw_q      <= req_rw;
                        addr_q    <= req_addr;
                        len_q     <= req_len;
                        idx       <= '0;
                        retry     <= '0;
                        error     <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= (req_len == '0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (iic_ready) begin
                        iic_start     <= 1'b1;
                        iic_rw_flag   <= rw_q;
                        iic_word_addr <= addr_q;
                        iic_wdata     <= ram_rdata;
                        ack_err       <= 1'b0;
                        state         <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (iic_ack_error) ack_err <= 1'b1;
                    if (!iic_ready) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (iic_ack_error) ack_err <= 1'b1;
                    if (iic_ready) begin
                        wait_cnt <= '0;
                        state    <= rw_q ? NEXT : WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (wait_cnt + 32'd1 >= WR_WAIT_CYC) state <= NEXT;
                    else wait_cnt <= wait_cnt + 32'd1;
                end
                NEXT: begin
                    if (ack_err) begin
                        if (retry < RETRY_MAX) begin
                            retry <= retry + RW'(1);
                            state <= ISSUE;
                        end else begin
                            error <= 1'b1;
                            state <= FINISH;
                        end
                    end else if (last) begin
                        state <= FINISH;
                    end else begin
                        idx    <= idx_nx[AW-1:0];
                        addr_q <= addr_q + WAW'(1);
                        retry  <= '0;
                        state  <= ISSUE;
                    end
                end
                FINISH: begin
                    done      <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (rd_strobe) begin
                rd_data  <= iic_rdata;
                rd_index <= idx;
                rd_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eeprom_seq_ctrl.sv
// Directed bench for eeprom_seq_ctrl: request table plus hand sequences for timing,
// ignored strobes, same-cycle buffer load and mid-operation reset.
module tb_eeprom_seq_ctrl;

    localparam int WCYC = 20;  // 1 MHz clock * 20 us

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       req_start = 1'b0, req_rw = 1'b0;
    logic [7:0] req_addr = '0;
    logic [4:0] req_len = '0;
    logic       req_ready;
    logic       buf_we = 1'b0;
    logic [3:0] buf_waddr = '0;
    logic [7:0] buf_wdata = '0;
    logic [7:0] rd_data;
    logic [3:0] rd_index;
    logic       rd_valid, done, error;
    logic       iic_start, iic_ready, iic_rw_flag;
    logic [7:0] iic_word_addr, iic_wdata, iic_rdata;
    logic       iic_rdata_valid, iic_ack_error;

    always #5 sys_clk = ~sys_clk;

    eeprom_seq_ctrl #(
        .SYS_CLK(1_000_000), .ADDR_BYTE_NUM(1), .BUF_DEPTH(16), .WR_WAIT_US(20), .MAX_RETRY(3)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_start(req_start), .req_rw(req_rw), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .rd_data(rd_data), .rd_index(rd_index), .rd_valid(rd_valid),
        .done(done), .error(error),
        .iic_start(iic_start), .iic_ready(iic_ready), .iic_rw_flag(iic_rw_flag),
        .iic_word_addr(iic_word_addr), .iic_wdata(iic_wdata), .iic_rdata(iic_rdata),
        .iic_rdata_valid(iic_rdata_valid), .iic_ack_error(iic_ack_error)
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, rd_k = 0;
    logic       err_en = 1'b0;
    logic [7:0] err_addr = '0;
    logic [7:0] st_addr[$], st_data[$], rdv_data[$];
    logic [3:0] rdv_idx[$];
    int         st_cyc[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (iic_start) begin
            st_addr.push_back(iic_word_addr);
            st_data.push_back(iic_wdata);
            st_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (rd_valid) begin
            rdv_data.push_back(rd_data);
            rdv_idx.push_back(rd_index);
        end
    end

    // IIC driver model: busy for three cycles, read data and ACK error in the last one.
    initial begin
        iic_ready = 1'b1; iic_rdata = '0; iic_rdata_valid = 1'b0; iic_ack_error = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (iic_start) begin
                iic_ready = 1'b0;
                repeat (2) @(negedge sys_clk);
                if (iic_rw_flag) begin
                    iic_rdata = 8'h5A + 8'(rd_k);
                    iic_rdata_valid = 1'b1;
                    rd_k++;
                end
                iic_ack_error = err_en && (iic_word_addr == err_addr);
                @(negedge sys_clk);
                iic_rdata_valid = 1'b0; iic_ack_error = 1'b0; iic_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic            rw;
        logic [7:0]      addr;
        logic [4:0]      len;
        logic [0:2][7:0] wd;
        logic            err_en;
        logic [7:0]      err_addr;
        int              n_st;
        logic [0:5][7:0] ea;  // word address of each iic_start
        logic [0:5][7:0] ed;  // write byte of each start, or read bytes returned
        logic            exp_err;
    } vec_t;

    function automatic vec_t mk(logic rw, logic [7:0] a, logic [4:0] l, logic [0:2][7:0] wd,
                                logic ee, logic [7:0] eaddr, int n, logic [0:5][7:0] ea,
                                logic [0:5][7:0] ed, logic xe);
        vec_t v;
        v.rw = rw; v.addr = a; v.len = l; v.wd = wd; v.err_en = ee; v.err_addr = eaddr;
        v.n_st = n; v.ea = ea; v.ed = ed; v.exp_err = xe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        @(negedge sys_clk); buf_we = 1'b1; buf_waddr = a; buf_wdata = d;
        @(negedge sys_clk); buf_we = 1'b0;
    endtask

    task automatic start_req(input logic rw, input logic [7:0] a, input logic [4:0] l);
        @(negedge sys_clk); req_start = 1'b1; req_rw = rw; req_addr = a; req_len = l;
        @(negedge sys_clk); req_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int n = 0;
        while (done_cnt == base && n < 3000) begin @(negedge sys_clk); n++; end
        chk({name, " done seen"}, 32'(n < 3000), 32'd1);
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic clr_logs();
        st_addr.delete(); st_data.delete(); st_cyc.delete();
        rdv_data.delete(); rdv_idx.delete(); rd_k = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 1);
        chk({tag, " iic_start"}, 32'(iic_start), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " error"}, 32'(error), 0);
        chk({tag, " rd_valid"}, 32'(rd_valid), 0);
        chk({tag, " iic_rw_flag"}, 32'(iic_rw_flag), 0);
        chk({tag, " iic_word_addr"}, 32'(iic_word_addr), 0);
        chk({tag, " iic_wdata"}, 32'(iic_wdata), 0);
        chk({tag, " rd_data"}, 32'(rd_data), 0);
        chk({tag, " rd_index"}, 32'(rd_index), 0);
    endtask

    vec_t vt [6];

    initial begin
        int base;
        int w;
        vt[0] = mk(0, 8'h10, 3, {8'hA1, 8'hA2, 8'hA3}, 0, 8'h00, 3,
                   {8'h10, 8'h11, 8'h12, 24'h0}, {8'hA1, 8'hA2, 8'hA3, 24'h0}, 0);
        vt[1] = mk(1, 8'h10, 3, 24'h0, 0, 8'h00, 3,
                   {8'h10, 8'h11, 8'h12, 24'h0}, {8'h5A, 8'h5B, 8'h5C, 24'h0}, 0);
        vt[2] = mk(0, 8'hFF, 2, {8'h11, 8'h22, 8'h00}, 0, 8'h00, 2,
                   {8'hFF, 8'h00, 32'h0}, {8'h11, 8'h22, 32'h0}, 0);
        vt[3] = mk(0, 8'h40, 3, {8'hC1, 8'hC2, 8'hC3}, 1, 8'h41, 5,
                   {8'h40, 8'h41, 8'h41, 8'h41, 8'h41, 8'h00},
                   {8'hC1, 8'hC2, 8'hC2, 8'hC2, 8'hC2, 8'h00}, 1);
        vt[4] = mk(0, 8'h60, 0, 24'h0, 0, 8'h00, 0, 48'h0, 48'h0, 0);
        vt[5] = mk(1, 8'hFE, 2, 24'h0, 0, 8'h00, 2,
                   {8'hFE, 8'hFF, 32'h0}, {8'h5A, 8'h5B, 32'h0}, 0);

        repeat (3) @(negedge sys_clk);
        chk_reset_vals("in reset");
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk_reset_vals("after reset");

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 3; k++) load(4'(k), vt[v].wd[k]);
            clr_logs();
            err_en = vt[v].err_en; err_addr = vt[v].err_addr;
            base = done_cnt;
            start_req(vt[v].rw, vt[v].addr, vt[v].len);
            wait_done(base, $sformatf("v%0d", v));
            chk($sformatf("v%0d start count", v), 32'(st_addr.size()), 32'(vt[v].n_st));
            for (int k = 0; k < vt[v].n_st && k < st_addr.size(); k++) begin
                chk($sformatf("v%0d addr[%0d]", v, k), 32'(st_addr[k]), 32'(vt[v].ea[k]));
                if (!vt[v].rw)
                    chk($sformatf("v%0d wdata[%0d]", v, k), 32'(st_data[k]), 32'(vt[v].ed[k]));
                if (!vt[v].rw && k > 0)
                    chk($sformatf("v%0d wr gap[%0d]", v, k),
                        32'(st_cyc[k] - st_cyc[k-1] >= WCYC), 1);
            end
            chk($sformatf("v%0d rd_valid count", v), 32'(rdv_data.size()),
                vt[v].rw ? 32'(vt[v].n_st) : 32'd0);
            for (int k = 0; k < rdv_data.size() && k < 6; k++) begin
                chk($sformatf("v%0d rd_data[%0d]", v, k), 32'(rdv_data[k]), 32'(vt[v].ed[k]));
                chk($sformatf("v%0d rd_index[%0d]", v, k), 32'(rdv_idx[k]), k);
            end
            chk($sformatf("v%0d done count", v), 32'(done_cnt - base), 1);
            chk($sformatf("v%0d error", v), 32'(error), 32'(vt[v].exp_err));
        end
        err_en = 1'b0;

        // Zero-length request: done exactly one cycle after FINISH entry.
        clr_logs();
        start_req(0, 8'h00, 0);
        chk("len0 done at finish", 32'(done), 0);
        chk("len0 ready at finish", 32'(req_ready), 0);
        @(negedge sys_clk);
        chk("len0 done pulse", 32'(done), 1);
        @(negedge sys_clk);
        chk("len0 done cleared", 32'(done), 0);
        chk("len0 no start", 32'(st_addr.size()), 0);

        // req_start and buf_we while busy are ignored.
        load(0, 8'h77);
        clr_logs(); base = done_cnt;
        start_req(0, 8'h30, 1);
        repeat (3) @(negedge sys_clk);
        req_start = 1'b1; req_addr = 8'h50; req_len = 3;
        buf_we = 1'b1; buf_waddr = 0; buf_wdata = 8'hEE;
        @(negedge sys_clk);
        req_start = 1'b0; buf_we = 1'b0;
        wait_done(base, "busy");
        chk("busy start count", 32'(st_addr.size()), 1);
        if (st_addr.size() > 0) chk("busy addr", 32'(st_addr[0]), 32'h30);
        chk("busy done count", 32'(done_cnt - base), 1);
        clr_logs(); base = done_cnt;
        start_req(0, 8'h31, 1);
        wait_done(base, "busy buf");
        if (st_data.size() > 0) chk("busy buf_we ignored", 32'(st_data[0]), 32'h77);
        else chk("busy buf start", 0, 1);

        // Same-cycle load and start: the request sends the old byte 0.
        load(0, 8'h33);
        clr_logs(); base = done_cnt;
        @(negedge sys_clk);
        req_start = 1'b1; req_rw = 0; req_addr = 8'h70; req_len = 1;
        buf_we = 1'b1; buf_waddr = 0; buf_wdata = 8'h44;
        @(negedge sys_clk);
        req_start = 1'b0; buf_we = 1'b0;
        wait_done(base, "same cycle");
        if (st_data.size() > 0) chk("same cycle old byte", 32'(st_data[0]), 32'h33);
        else chk("same cycle start", 0, 1);
        clr_logs(); base = done_cnt;
        start_req(0, 8'h71, 1);
        wait_done(base, "same cycle next");
        if (st_data.size() > 0) chk("same cycle new byte", 32'(st_data[0]), 32'h44);
        else chk("same cycle next start", 0, 1);

        // Reset while waiting on the driver aborts without done.
        clr_logs(); base = done_cnt;
        start_req(0, 8'h80, 2);
        w = 0;
        while (st_addr.size() == 0 && w < 200) begin @(negedge sys_clk); w++; end
        chk("rst start seen", 32'(w < 200), 1);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk_reset_vals("abort reset");
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (10) @(negedge sys_clk);
        chk("abort no done", 32'(done_cnt - base), 0);
        chk("abort start count", 32'(st_addr.size()), 1);
        load(0, 8'h99);
        clr_logs(); base = done_cnt;
        start_req(0, 8'h90, 1);
        wait_done(base, "post reset");
        chk("post reset start count", 32'(st_addr.size()), 1);
        if (st_addr.size() > 0) begin
            chk("post reset addr", 32'(st_addr[0]), 32'h90);
            chk("post reset data", 32'(st_data[0]), 32'h99);
        end
        chk("post reset done count", 32'(done_cnt - base), 1);
        chk("post reset error", 32'(error), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
